rx: RTL and testbench
=====================

# rx

Serial receive block for the mini SPART RS232 path: it deserializes 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from `RxD` into a byte register and raises a data-available flag for the bus interface. It shares the 16x-oversampled baud enable `en` with the transmit block. It is the receiving end of the same serial link the transmitter drives.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the `RxD` metastability synchronizer. Legal values are 2 or 3.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: baud enable from the baud generator, one `clk` cycle wide, 16 pulses per bit time.
- `RxD` input 1: asynchronous serial line; idle level is high.
- `clr_rda` input 1: one-cycle acknowledge from the bus interface meaning "byte read"; clears `rda` and `ovr`.
- `data` output 8: last received byte, registered.
- `rda` output 1: received data available, registered.
- `ferr` output 1: framing error for the byte currently in `data`.
- `ovr` output 1: overrun; a byte completed while `rda` was already 1.

## Operation
- `RxD` passes through `SYNC_STAGES` flip-flops, each reset to 1. All logic below uses the synchronized value `rxs`.
- State register has four states: IDLE, START, DATA, STOP, plus BREAK (five states in total; 3-bit encoding). A 4-bit tick counter `tcnt` and a 3-bit bit counter `bcnt` support it.
- `tcnt` and all state transitions advance only on `clk` edges where `en`=1. `clk` edges with `en`=0 hold all state.
- **IDLE**: on an `en` cycle with `rxs`=0, go to START with `tcnt`←0. That detection tick is tick 0.
- **START**: `tcnt` increments on each `en`. At the sample decision point, if the sampled value is 1 it is a false start and the block returns to IDLE with no output change. When `tcnt` wraps 15→0, go to DATA with `bcnt`←0.
- **DATA**: at each decision point, shift in the sample: `shreg`←{sample, `shreg[7:1]`}. When `tcnt` wraps, either `bcnt`←`bcnt`+1, or, if `bcnt`=7, go to STOP.
- **STOP**: at the decision point:
  - `data`←`shreg` and `rda`←1.
  - If the sample is 1: `ferr`←0 and go to IDLE.
  - If the sample is 0: `ferr`←1 and go to BREAK.
- **BREAK**: stay until an `en` cycle sees `rxs`=1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- **Overrun**: if the STOP decision occurs while `rda`=1 and `clr_rda`=0, set `ovr`←1 and overwrite `data`.
- **Simultaneous `clr_rda` and STOP decision**: the new byte wins. `rda` stays 1 and `ovr` is not set.
- `clr_rda` outside a STOP decision clears `rda` and `ovr` on the next edge. `ferr` holds until the next byte completes.
- **Reset** (async, also mid-frame): state IDLE, `tcnt`=0, `bcnt`=0, `shreg`=0, `data`=8'h00, `rda`=0, `ferr`=0, `ovr`=0. Synchronizer flip-flops reset to 1.

## Timing
- Decision point is `tcnt`=9 with majority voting, or `tcnt`=8 with single sampling. The sample is taken on an `en` cycle.
- `rda`, `data` and `ferr` update on the `clk` edge of the stop-bit decision `en` cycle. That edge is 152 (or 153 with majority) `en` ticks after tick 0, plus the synchronizer delay of `SYNC_STAGES` cycles from the `RxD` edge.
- After a good stop bit the return to IDLE is immediate. The next start bit may begin at any later `en` tick.
- `rda` drops one cycle after `clr_rda` is sampled high. No combinational path exists from inputs to outputs.

## Configuration
- `RX_MAJORITY_EN` defined:
  - Samples are taken at `tcnt`=7, 8 and 9, and the bit value is the 2-of-3 majority.
  - Start validation, data bits and the stop bit all use the majority value.
  - The decision point is `tcnt`=9.
- `RX_MAJORITY_EN` undefined: a single sample is taken at `tcnt`=8, which is also the decision point. The three-sample registers are not built.

## Test plan
- **Loopback**: transmitter `TxD` feeds `RxD`; send 8'hA5 → `data`=8'hA5, `rda`=1, `ferr`=0, `ovr`=0. Then pulse `clr_rda` → `rda`=0 one cycle later.
- **False start**: drive `RxD` low for 4 `en` ticks, then high → state returns to IDLE, `rda` stays 0, and a following 8'h3C frame is received correctly.
- **Framing error**: send 8'h3C with stop bit 0 and hold `RxD` low for 40 ticks → `rda`=1, `ferr`=1, and no second byte appears until `RxD` returns high. The next 8'h55 frame gives `ferr`=0.
- **Overrun**: send 8'h11 then 8'h22 without `clr_rda` → `data`=8'h22, `ovr`=1. Then `clr_rda` → `rda`=0, `ovr`=0.
- **Simultaneous**: assert `clr_rda` on the exact STOP decision cycle of the second byte → `rda`=1, `ovr`=0, `data`=new byte.
- **Reset mid-frame, then glitch**:
  - Assert `rst` during bit 4 → all outputs 0 immediately; the next full frame 8'hF0 is received correctly.
  - With `RX_MAJORITY_EN`, a one-tick inverted glitch at `tcnt`=8 of bit 2 still gives the correct byte.

Source files
------------

// File: rtl/rx.sv
// rx: 8N1 serial receiver for the mini SPART RS232 path.
// Deserializes frames from RxD using the shared 16x baud enable `en`,
// presents the byte on `data` with a data-available flag `rda`, a framing
// error flag `ferr` and an overrun flag `ovr`.
// Optional feature macro: RX_MAJORITY_EN -- when defined, each bit is the
// 2-of-3 majority of samples taken at tcnt = 7, 8, 9; otherwise a single
// sample is taken at tcnt = 8.
// Counting note: a tick "at tcnt = N" is the en cycle on which tcnt
// advances to N, so with the line edge seen on tick 0 the single-sample
// point falls on the middle tick of each bit.
module rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       RxD,
    input  logic       clr_rda,
    output logic [7:0] data,
    output logic       rda,
    output logic       ferr,
    output logic       ovr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // RxD metastability synchronizer, idle-high after reset
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous line
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_q[gi] <= 1'b1;
                    else     sync_q[gi] <= RxD;
                end
            end else begin : g_rest
                // Later stages resolve metastability of the previous one
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_q[gi] <= 1'b1;
                    else     sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rxs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Bit sampling
    // ------------------------------------------------------------------
    logic [3:0] tcnt_q, tcnt_d;
    logic       bit_val;

`ifdef RX_MAJORITY_EN
    // Decision on the tick that takes tcnt to 9; the first two samples are
    // stored and the third is the live synchronized value.
    localparam logic [3:0] DEC_CNT = 4'd8;
    logic [1:0] samp_q, samp_d;

    always_comb begin
        samp_d = samp_q;
        if (en && tcnt_q == 4'd6) samp_d[0] = rxs;
        if (en && tcnt_q == 4'd7) samp_d[1] = rxs;
    end

    // Hold the tcnt = 7 and tcnt = 8 samples for the vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) samp_q <= 2'b11;
        else     samp_q <= samp_d;
    end

    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
`else
    // Single sample on the tick that takes tcnt to 8
    localparam logic [3:0] DEC_CNT = 4'd7;
    assign bit_val = rxs;
`endif

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       rda_q, rda_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       decide;

    assign decide = en && (tcnt_q == DEC_CNT);

    // Next-state and output-register computation
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rda_d   = rda_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        // Bus acknowledge; a coincident stop decision below overrides it
        if (clr_rda) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        tcnt_d  = 4'd0;
                    end
                end
                S_START: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (decide && bit_val) begin
                        // Line went back high: glitch, not a start bit
                        state_d = S_IDLE;
                        tcnt_d  = 4'd0;
                    end else if (tcnt_q == 4'd15) begin
                        state_d = S_DATA;
                        bcnt_d  = 3'd0;
                    end
                end
                S_DATA: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (decide) shreg_d = {bit_val, shreg_q[7:1]};
                    if (tcnt_q == 4'd15) begin
                        if (bcnt_q == 3'd7) state_d = S_STOP;
                        else                bcnt_d  = bcnt_q + 3'd1;
                    end
                end
                S_STOP: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (decide) begin
                        data_d = shreg_q;
                        rda_d  = 1'b1;
                        if (rda_q && !clr_rda) ovr_d = 1'b1;
                        ferr_d  = ~bit_val;
                        state_d = bit_val ? S_IDLE : S_BREAK;
                        tcnt_d  = 4'd0;
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line before looking for a start bit
                    if (rxs) begin
                        state_d = S_IDLE;
                        tcnt_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= 4'd0;
            bcnt_q  <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            rda_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rda_q   <= rda_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data = data_q;
    assign rda  = rda_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_rx.sv
// tb_rx: directed self-checking bench for rx. The bench drives RxD as an
// 8N1 transmitter aligned to en ticks (en = 1 clk in 4).
module tb_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       RxD = 1'b1;
    logic       clr_rda = 1'b0;
    logic [7:0] data;
    logic       rda;
    logic       ferr;
    logic       ovr;

    logic [1:0] ecnt = 2'd0;
    int         n_checks = 0;
    int         n_pass = 0;

    rx #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .RxD     (RxD),
        .clr_rda (clr_rda),
        .data    (data),
        .rda     (rda),
        .ferr    (ferr),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    // Baud enable: one clk cycle high out of every four, changed on negedge
    always @(negedge clk) begin
        ecnt <= ecnt + 2'd1;
        en   <= (ecnt == 2'd3);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
            $display("check %s: got %h expected %h", tag, got, exp);
        end else begin
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Return #1 after the next clk edge on which en is high
    task automatic wait_en();
        @(posedge clk);
        while (!en) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) wait_en();
    endtask

    // One bit time; optional one-tick inverted glitch at tcnt = 8
    task automatic send_bit(input logic v, input bit glitch);
        RxD = v;
        if (glitch) begin
            ticks(8);
            RxD = ~v;
            ticks(1);
            RxD = v;
            ticks(7);
        end else begin
            ticks(16);
        end
    endtask

    // Full frame; clr_at_dec pulses clr_rda on exactly the stop decision cycle
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int glitch_bit, input bit clr_at_dec);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], (i == glitch_bit));
        RxD = stop_v;
        if (clr_at_dec) begin
            ticks(8);
            repeat (3) @(posedge clk);
            #1 clr_rda = 1'b1;
            @(posedge clk);
            #1 clr_rda = 1'b0;
            ticks(7);
        end else begin
            ticks(16);
        end
    endtask

    task automatic pulse_clr(input string tag);
        clr_rda = 1'b1;
        @(posedge clk);
        #1 clr_rda = 1'b0;
        check(tag, {7'd0, rda}, 8'h00);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_data", data, 8'h00);
        check("reset_rda", {7'd0, rda}, 8'h00);
        check("reset_ferr", {7'd0, ferr}, 8'h00);
        check("reset_ovr", {7'd0, ovr}, 8'h00);
        ticks(4);

        // Plain frame 0xA5
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        check("a5_data", data, 8'hA5);
        check("a5_rda", {7'd0, rda}, 8'h01);
        check("a5_ferr", {7'd0, ferr}, 8'h00);
        check("a5_ovr", {7'd0, ovr}, 8'h00);
        pulse_clr("a5_clr_rda");

        // False start: 4 low ticks, then a good 0x3C frame
        RxD = 1'b0;
        ticks(4);
        RxD = 1'b1;
        ticks(20);
        check("false_start_rda", {7'd0, rda}, 8'h00);
        check("false_start_data", data, 8'hA5);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        check("after_false_data", data, 8'h3C);
        check("after_false_rda", {7'd0, rda}, 8'h01);
        pulse_clr("after_false_clr");

        // Framing error with the line held low for 40 ticks total
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        check("ferr_data", data, 8'h3C);
        check("ferr_rda", {7'd0, rda}, 8'h01);
        check("ferr_flag", {7'd0, ferr}, 8'h01);
        pulse_clr("ferr_clr");
        ticks(24);
        check("break_no_byte", {7'd0, rda}, 8'h00);
        RxD = 1'b1;
        ticks(4);
        send_frame(8'h55, 1'b1, -1, 1'b0);
        check("post_break_data", data, 8'h55);
        check("post_break_ferr", {7'd0, ferr}, 8'h00);
        check("post_break_rda", {7'd0, rda}, 8'h01);
        pulse_clr("post_break_clr");

        // Overrun
        send_frame(8'h11, 1'b1, -1, 1'b0);
        check("ovr_first_ovr", {7'd0, ovr}, 8'h00);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        check("ovr_data", data, 8'h22);
        check("ovr_flag", {7'd0, ovr}, 8'h01);
        check("ovr_rda", {7'd0, rda}, 8'h01);
        pulse_clr("ovr_clr_rda");
        check("ovr_clr_ovr", {7'd0, ovr}, 8'h00);

        // clr_rda coincident with the stop decision: new byte wins
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        check("simul_first_rda", {7'd0, rda}, 8'h01);
        send_frame(8'hC3, 1'b1, -1, 1'b1);
        check("simul_rda", {7'd0, rda}, 8'h01);
        check("simul_ovr", {7'd0, ovr}, 8'h00);
        check("simul_data", data, 8'hC3);

        // Async reset during bit 4 of a frame (0xF0: bits 0-3 low, bit 4 high)
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        RxD = 1'b1;
        ticks(5);
        #2 rst = 1'b1;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_rda", {7'd0, rda}, 8'h00);
        check("midrst_ferr", {7'd0, ferr}, 8'h00);
        check("midrst_ovr", {7'd0, ovr}, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ticks(20);
        check("midrst_idle_rda", {7'd0, rda}, 8'h00);
        send_frame(8'hF0, 1'b1, -1, 1'b0);
        check("post_rst_data", data, 8'hF0);
        check("post_rst_rda", {7'd0, rda}, 8'h01);
        check("post_rst_ferr", {7'd0, ferr}, 8'h00);

`ifdef RX_MAJORITY_EN
        // One-tick glitch at tcnt = 8 of bit 2 is outvoted
        pulse_clr("glitch_pre_clr");
        send_frame(8'h96, 1'b1, 2, 1'b0);
        check("glitch_data", data, 8'h96);
        check("glitch_rda", {7'd0, rda}, 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
